// File: rtl/dbus_uart_master.sv
// UART-driven debug initiator: parses 'W'/'R' byte frames from a uart_lite RX port,
// issues single-word dBus commands and returns 'K' / read data / 'E' / 'T' on TX.
module dbus_uart_master #(
  parameter int CLK_FREQ            = 100000000,
  parameter int WL                  = 32,
  parameter int BYTE_TIMEOUT_CYCLES = 1000000,
  parameter int RSP_TIMEOUT_CYCLES  = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx_valid,
  input  logic [7:0]    rx_data,
  input  logic          tx_rdy,
  output logic          tx_vld,
  output logic [7:0]    tx_data,
  output logic          dbus_cmd_valid,
  input  logic          dbus_cmd_ready,
  output logic          dbus_cmd_payload_wr,
  output logic [WL-1:0] dbus_cmd_payload_address,
  output logic [WL-1:0] dbus_cmd_payload_data,
  output logic [1:0]    dbus_cmd_payload_size,
  input  logic          dbus_rsp_ready,
  input  logic          dbus_rsp_error,
  input  logic [WL-1:0] dbus_rsp_data,
  output logic          busy,
  output logic          rx_overrun
);

  // state   | meaning
  // IDLE    | waiting for a 'W' or 'R' command byte
  // ADDR    | collecting 4 address bytes, MSB first
  // DATA    | collecting 4 write-data bytes, MSB first
  // BUS_CMD | dbus_cmd_valid held until accepted
  // BUS_RSP | waiting for read response or response timeout
  // TX_RESP | draining the response bytes to the UART
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ADDR    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] BUS_CMD = 3'd3;
  localparam logic [2:0] BUS_RSP = 3'd4;
  localparam logic [2:0] TX_RESP = 3'd5;

  localparam logic [7:0] CH_W = 8'h57;
  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;
  localparam logic [7:0] CH_T = 8'h54;

  localparam int BT_W = $clog2(BYTE_TIMEOUT_CYCLES + 1);
  localparam int RT_W = $clog2(RSP_TIMEOUT_CYCLES + 1);
  localparam logic [BT_W-1:0] BT_LOAD = BT_W'(BYTE_TIMEOUT_CYCLES);
  // Loaded at accept so the terminal-count cycle is RSP_TIMEOUT_CYCLES after it.
  localparam logic [RT_W-1:0] RT_LOAD = RT_W'(RSP_TIMEOUT_CYCLES - 1);

  if (WL != 32 || CLK_FREQ <= 0 || RSP_TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dbus_uart_master: WL must be 32, CLK_FREQ and RSP_TIMEOUT_CYCLES positive");
  end

  logic [2:0]      state;
  logic [1:0]      byte_idx;
  logic [BT_W-1:0] byte_tmr;
  logic [RT_W-1:0] rsp_tmr;
  logic [31:0]     resp_buf;
  logic [2:0]      resp_left;

  assign dbus_cmd_payload_size = 2'b10;
  assign busy                  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= IDLE;
      byte_idx                 <= '0;
      byte_tmr                 <= '0;
      rsp_tmr                  <= '0;
      resp_buf                 <= '0;
      resp_left                <= '0;
      tx_vld                   <= 1'b0;
      tx_data                  <= '0;
      dbus_cmd_valid           <= 1'b0;
      dbus_cmd_payload_wr      <= 1'b0;
      dbus_cmd_payload_address <= '0;
      dbus_cmd_payload_data    <= '0;
      rx_overrun               <= 1'b0;
    end else begin
      rx_overrun <= rx_valid &&
                    (state == BUS_CMD || state == BUS_RSP || state == TX_RESP);
      case (state)
        IDLE: begin
          if (rx_valid && (rx_data == CH_W || rx_data == CH_R)) begin
            dbus_cmd_payload_wr <= (rx_data == CH_W);
            byte_idx            <= '0;
            byte_tmr            <= BT_LOAD;
            state               <= ADDR;
          end
        end
        ADDR: begin
          if (rx_valid) begin
            dbus_cmd_payload_address <= {dbus_cmd_payload_address[WL-9:0], rx_data};
            byte_idx                 <= byte_idx + 2'd1;
            byte_tmr                 <= BT_LOAD;
            if (byte_idx == 2'd3) begin
              if (dbus_cmd_payload_wr) begin
                state <= DATA;
              end else begin
                dbus_cmd_valid <= 1'b1;
                state          <= BUS_CMD;
              end
            end
          end else if (byte_tmr == '0) begin
            state <= IDLE;
          end else begin
            byte_tmr <= byte_tmr - 1'b1;
          end
        end
        DATA: begin
          if (rx_valid) begin
            dbus_cmd_payload_data <= {dbus_cmd_payload_data[WL-9:0], rx_data};
            byte_idx              <= byte_idx + 2'd1;
            byte_tmr              <= BT_LOAD;
            if (byte_idx == 2'd3) begin
              dbus_cmd_valid <= 1'b1;
              state          <= BUS_CMD;
            end
          end else if (byte_tmr == '0) begin
            state <= IDLE;
          end else begin
            byte_tmr <= byte_tmr - 1'b1;
          end
        end
        BUS_CMD: begin
          if (dbus_cmd_ready) begin
            dbus_cmd_valid <= 1'b0;
            if (dbus_cmd_payload_wr) begin
              tx_vld    <= 1'b1;
              tx_data   <= CH_K;
              resp_left <= 3'd0;
              state     <= TX_RESP;
            end else begin
              rsp_tmr <= RT_LOAD;
              state   <= BUS_RSP;
            end
          end
        end
        BUS_RSP: begin
          // A response landing on the terminal-count cycle still wins.
          if (dbus_rsp_ready) begin
            tx_vld <= 1'b1;
            state  <= TX_RESP;
            if (dbus_rsp_error) begin
              tx_data   <= CH_E;
              resp_left <= 3'd0;
            end else begin
              tx_data   <= CH_K;
              resp_buf  <= dbus_rsp_data;
              resp_left <= 3'd4;
            end
          end else if (rsp_tmr == '0) begin
            tx_vld    <= 1'b1;
            tx_data   <= CH_T;
            resp_left <= 3'd0;
            state     <= TX_RESP;
          end else begin
            rsp_tmr <= rsp_tmr - 1'b1;
          end
        end
        TX_RESP: begin
          if (tx_rdy) begin
            if (resp_left == 3'd0) begin
              tx_vld <= 1'b0;
              state  <= IDLE;
            end else begin
              tx_data   <= resp_buf[31:24];
              resp_buf  <= {resp_buf[23:0], 8'h00};
              resp_left <= resp_left - 3'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_uart_master.sv
// Scoreboard bench for dbus_uart_master: frames are issued with random timing, the
// expected bus command and UART reply are queued from the frame rules and popped by a monitor.
module tb_dbus_uart_master;
  localparam int BT     = 100;
  localparam int RSP_TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_rdy;
  logic        tx_vld;
  logic [7:0]  tx_data;
  logic        dbus_cmd_valid;
  logic        dbus_cmd_ready;
  logic        dbus_cmd_payload_wr;
  logic [31:0] dbus_cmd_payload_address;
  logic [31:0] dbus_cmd_payload_data;
  logic [1:0]  dbus_cmd_payload_size;
  logic        dbus_rsp_ready;
  logic        dbus_rsp_error;
  logic [31:0] dbus_rsp_data;
  logic        busy;
  logic        rx_overrun;

  dbus_uart_master #(
    .CLK_FREQ(100000000), .WL(32),
    .BYTE_TIMEOUT_CYCLES(BT), .RSP_TIMEOUT_CYCLES(RSP_TO)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_rdy(tx_rdy), .tx_vld(tx_vld), .tx_data(tx_data),
    .dbus_cmd_valid(dbus_cmd_valid), .dbus_cmd_ready(dbus_cmd_ready),
    .dbus_cmd_payload_wr(dbus_cmd_payload_wr),
    .dbus_cmd_payload_address(dbus_cmd_payload_address),
    .dbus_cmd_payload_data(dbus_cmd_payload_data),
    .dbus_cmd_payload_size(dbus_cmd_payload_size),
    .dbus_rsp_ready(dbus_rsp_ready), .dbus_rsp_error(dbus_rsp_error),
    .dbus_rsp_data(dbus_rsp_data),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t        exp_cmd[$];
  logic [7:0]  exp_tx[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          ovr_seen = 0;
  int          ovr_exp = 0;
  int          acc_cyc = 0;
  int          tx_rise_cyc = 0;

  // 0 = random, 1 = tied high, 2 = tied low
  int          rdy_mode = 1;
  bit          tx_hold = 1'b0;
  // 0 = data response, 1 = error response, 2 = no response
  int          rsp_mode = 0;
  int          rsp_delay = 3;
  logic [31:0] rsp_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: what a frame must produce on the bus and on the UART.
  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    cmd_t c;
    c.wr = 1'b1; c.addr = a; c.data = d;
    exp_cmd.push_back(c);
    exp_tx.push_back(8'h4B);
  endtask

  task automatic expect_read(input logic [31:0] a, input int mode, input logic [31:0] rd);
    cmd_t c;
    c.wr = 1'b0; c.addr = a; c.data = '0;
    exp_cmd.push_back(c);
    if (mode == 1) exp_tx.push_back(8'h45);
    else if (mode == 2) exp_tx.push_back(8'h54);
    else begin
      exp_tx.push_back(8'h4B);
      for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  // long_at: index of the byte followed by a gap of exactly BT idle cycles (-1 = none)
  task automatic send_frame(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input int gmax, input int long_at);
    logic [7:0] b[$];
    b.push_back(c);
    for (int i = 3; i >= 0; i--) b.push_back(a[8*i +: 8]);
    if (c == 8'h57) for (int i = 3; i >= 0; i--) b.push_back(d[8*i +: 8]);
    foreach (b[i]) begin
      send_byte(b[i]);
      if (i != b.size() - 1) tick((i == long_at) ? BT : int'($urandom_range(0, gmax)));
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy || exp_tx.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) begin
      fail({name, "_idle_timeout"});
      exp_tx.delete();
      exp_cmd.delete();
    end else begin
      chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // Drives the ready-side handshakes a cycle at a time.
  initial begin
    tx_rdy = 1'b0;
    dbus_cmd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_rdy = tx_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
      case (rdy_mode)
        1: dbus_cmd_ready = 1'b1;
        2: dbus_cmd_ready = 1'b0;
        default: dbus_cmd_ready = $urandom_range(0, 1) != 0;
      endcase
    end
  end

  // Bus slave: answers accepted reads rsp_delay cycles after the accept cycle.
  initial begin
    dbus_rsp_ready = 1'b0;
    dbus_rsp_error = 1'b0;
    dbus_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!reset && dbus_cmd_valid && dbus_cmd_ready && !dbus_cmd_payload_wr) begin
        acc_cyc = cyc;
        if (rsp_mode != 2) begin
          repeat (rsp_delay) @(posedge clk);
          #1;
          dbus_rsp_ready = 1'b1;
          dbus_rsp_error = (rsp_mode == 1);
          dbus_rsp_data  = rsp_word;
          @(posedge clk);
          #1;
          dbus_rsp_ready = 1'b0;
          dbus_rsp_error = 1'b0;
          dbus_rsp_data  = $urandom;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold-stability.
  initial begin
    cmd_t        e;
    logic [7:0]  et;
    bit          p_rst = 1'b1, p_cmd_hold = 1'b0, p_tx_hold = 1'b0, p_tx_vld = 1'b0;
    logic [31:0] p_addr = '0, p_data = '0;
    logic        p_wr = 1'b0;
    logic [7:0]  p_txd = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (dbus_cmd_valid && dbus_cmd_ready) begin
          if (exp_cmd.size() == 0) fail("unexpected_cmd");
          else begin
            e = exp_cmd.pop_front();
            chk("cmd_wr", {31'd0, dbus_cmd_payload_wr}, {31'd0, e.wr});
            chk("cmd_addr", dbus_cmd_payload_address, e.addr);
            if (e.wr) chk("cmd_data", dbus_cmd_payload_data, e.data);
            chk("cmd_size", {30'd0, dbus_cmd_payload_size}, 32'd2);
          end
        end
        if (tx_vld && tx_rdy) begin
          if (exp_tx.size() == 0) fail("unexpected_tx");
          else begin
            et = exp_tx.pop_front();
            chk("tx_byte", {24'd0, tx_data}, {24'd0, et});
          end
        end
        if (!p_rst && p_cmd_hold) begin
          chk("cmd_valid_held", {31'd0, dbus_cmd_valid}, 32'd1);
          chk("cmd_addr_stable", dbus_cmd_payload_address, p_addr);
          chk("cmd_wr_stable", {31'd0, dbus_cmd_payload_wr}, {31'd0, p_wr});
          if (p_wr) chk("cmd_data_stable", dbus_cmd_payload_data, p_data);
        end
        if (!p_rst && p_tx_hold) begin
          chk("tx_vld_held", {31'd0, tx_vld}, 32'd1);
          chk("tx_data_stable", {24'd0, tx_data}, {24'd0, p_txd});
        end
        if (tx_vld && !p_tx_vld) tx_rise_cyc = cyc;
        if (rx_overrun) ovr_seen++;
      end
      p_rst      = reset;
      p_cmd_hold = dbus_cmd_valid && !dbus_cmd_ready;
      p_tx_hold  = tx_vld && !tx_rdy;
      p_tx_vld   = tx_vld;
      p_addr     = dbus_cmd_payload_address;
      p_data     = dbus_cmd_payload_data;
      p_wr       = dbus_cmd_payload_wr;
      p_txd      = tx_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ovr0;
    logic [31:0] a, d;
    reset = 1'b1;
    rx_valid = 1'b0;
    rx_data = '0;
    tick(3);
    @(negedge clk);
    chk("rst_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_cmd_valid", {31'd0, dbus_cmd_valid}, 32'd0);
    chk("rst_wr", {31'd0, dbus_cmd_payload_wr}, 32'd0);
    chk("rst_addr", dbus_cmd_payload_address, 32'd0);
    chk("rst_data", dbus_cmd_payload_data, 32'd0);
    chk("rst_size", {30'd0, dbus_cmd_payload_size}, 32'd2);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick(2);

    // Write with cmd_ready tied high; command must appear the cycle after the last byte.
    rdy_mode = 1;
    expect_write(32'h8000000C, 32'h00000005);
    send_frame(8'h57, 32'h8000000C, 32'h00000005, 0, -1);
    @(negedge clk);
    chk("cmd_first_valid", {31'd0, dbus_cmd_valid}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle("write1", 200);

    // Stray response while idle, then a read answered 3 cycles after accept.
    rdy_mode = 0;
    dbus_rsp_ready = 1'b1;
    tick(1);
    dbus_rsp_ready = 1'b0;
    rsp_mode = 0; rsp_delay = 3; rsp_word = 32'hDEADBEEF;
    expect_read(32'h00000100, 0, 32'hDEADBEEF);
    send_frame(8'h52, 32'h00000100, 32'h0, 2, -1);
    wait_idle("read_ok", 300);

    rsp_mode = 1; rsp_delay = 5;
    expect_read(32'h40000004, 1, 32'h0);
    send_frame(8'h52, 32'h40000004, 32'h0, 2, -1);
    wait_idle("read_err", 300);

    rsp_mode = 2;
    expect_read(32'h12345678, 2, 32'h0);
    send_frame(8'h52, 32'h12345678, 32'h0, 2, -1);
    wait_idle("read_timeout", 300);
    lat = tx_rise_cyc - acc_cyc;
    chk("rsp_timeout_latency_ok", {31'd0, (lat >= RSP_TO && lat <= RSP_TO + 2)}, 32'd1);

    // Partial frame abandoned: held before the timeout, discarded after it.
    send_byte(8'h57);
    send_byte(8'h12);
    send_byte(8'h34);
    tick(BT - 10);
    chk("frame_held_before_timeout", {31'd0, busy}, 32'd1);
    tick(60);
    chk("frame_dropped_after_timeout", {31'd0, busy}, 32'd0);
    rsp_mode = 0; rsp_delay = 1; rsp_word = 32'hA5C3_0F96;
    expect_read(32'hCAFE0010, 0, 32'hA5C3_0F96);
    send_frame(8'h52, 32'hCAFE0010, 32'h0, 1, -1);
    wait_idle("read_after_timeout", 300);

    // A byte landing exactly on the timeout terminal count must be kept.
    expect_write(32'h0BAD_F00D, 32'h1357_9BDF);
    send_frame(8'h57, 32'h0BAD_F00D, 32'h1357_9BDF, 0, 2);
    wait_idle("write_boundary_gap", 300);

    // Bytes arriving while the reply is stalled are dropped with one pulse each.
    tx_hold = 1'b1;
    expect_write(32'h00000040, 32'hFFFF0000);
    send_frame(8'h57, 32'h00000040, 32'hFFFF0000, 0, -1);
    ovr0 = ovr_seen;
    for (int i = 0; i < 50 && !tx_vld; i++) tick(1);
    chk("tx_vld_under_hold", {31'd0, tx_vld}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      if (i % 10 == 3) begin
        rx_data = 8'h52;
        rx_valid = 1'b1;
        ovr_exp++;
      end
      tick(1);
      rx_valid = 1'b0;
    end
    tick(2);
    chk("overrun_pulses", ovr_seen - ovr0, 32'd5);
    tx_hold = 1'b0;
    wait_idle("write_overrun", 200);

    // Reset while a command is stuck waiting for ready.
    rdy_mode = 2;
    send_frame(8'h52, 32'h00000200, 32'h0, 0, -1);
    tick(3);
    @(negedge clk);
    chk("cmd_stuck_valid", {31'd0, dbus_cmd_valid}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_cmd_valid", {31'd0, dbus_cmd_valid}, 32'd0);
    chk("rst_mid_tx_vld", {31'd0, tx_vld}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    rdy_mode = 0;

    // Junk bytes in IDLE are silently ignored.
    ovr0 = ovr_seen;
    send_byte(8'h00);
    send_byte(8'h41);
    tick(3);
    chk("junk_not_busy", {31'd0, busy}, 32'd0);
    chk("junk_no_overrun", ovr_seen - ovr0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      d = $urandom;
      if ($urandom_range(0, 4) == 0) send_byte(8'h20);
      if ($urandom_range(0, 1) != 0) begin
        expect_write(a, d);
        send_frame(8'h57, a, d, 3, -1);
      end else begin
        rsp_mode  = ($urandom_range(0, 9) == 0) ? 1 : 0;
        rsp_delay = $urandom_range(1, 12);
        rsp_word  = $urandom;
        expect_read(a, rsp_mode, rsp_word);
        send_frame(8'h52, a, 32'h0, 3, -1);
      end
      wait_idle("random", 400);
    end

    tick(5);
    chk("cmd_queue_drained", exp_cmd.size(), 32'd0);
    chk("tx_queue_drained", exp_tx.size(), 32'd0);
    chk("overrun_total", ovr_seen, ovr_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dbus_uart_master.md
Name: dbus_uart_master

Overview:
- UART-driven debug initiator for the VexRiscv dBus-style memory/IO fabric.
- Parses byte frames arriving from a uart_lite RX port and issues single-word read/write commands on a dBus-compatible cmd/rsp interface.
- Returns an ack, read data or an error code through the uart_lite TX port.
- Sits beside the CPU in front of the RAM/IO mux. Used for program load, peek/poke of IO registers, and bring-up without firmware.

Parameters:
- CLK_FREQ, 100000000, clock frequency in Hz (informational; timeouts are given in cycles).
- WL, 32, bus address/data width; must be 32.
- BYTE_TIMEOUT_CYCLES, 1000000, idle cycles allowed between bytes of one frame before the frame is discarded.
- RSP_TIMEOUT_CYCLES, 1024, cycles allowed from read-command acceptance to dbus_rsp_ready.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_rdy  in  1  UART transmitter can accept a byte
- tx_vld  out  1  byte on tx_data is valid
- tx_data  out  8  byte to transmit
- dbus_cmd_valid  out  1  command valid
- dbus_cmd_ready  in  1  command accepted
- dbus_cmd_payload_wr  out  1  1 = write, 0 = read
- dbus_cmd_payload_address  out  32  byte address
- dbus_cmd_payload_data  out  32  write data
- dbus_cmd_payload_size  out  2  always 2'b10 (word)
- dbus_rsp_ready  in  1  one-cycle read response strobe
- dbus_rsp_error  in  1  read response error, sampled with dbus_rsp_ready
- dbus_rsp_data  in  32  read data, sampled with dbus_rsp_ready
- busy  out  1  high in any state other than IDLE
- rx_overrun  out  1  one-cycle pulse: a byte was dropped because the block was not parsing

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Reset mid-operation aborts any frame, bus transaction or response immediately.
- Reset values: tx_vld=0, tx_data=0, dbus_cmd_valid=0, wr=0, address=0, data=0, size=2'b10, busy=0, rx_overrun=0; state=IDLE; all counters 0.
- Frame format:
  - Command byte: 0x57 'W' or 0x52 'R'.
  - Then 4 address bytes, MSB first.
  - 'W' frames add 4 data bytes, MSB first.
  - Any other command byte in IDLE is ignored silently: no response, no overrun pulse.
- State machine:
  - IDLE: on rx_valid with a valid command byte, latch wr and go to ADDR with the byte counter at 0.
  - ADDR: shift each byte into the address register. After the 4th byte, go to DATA if wr=1, else to BUS_CMD.
  - DATA: shift 4 bytes into the data register, then go to BUS_CMD.
  - BUS_CMD: hold dbus_cmd_valid=1 with a stable payload until dbus_cmd_valid && dbus_cmd_ready. First valid cycle is the cycle after the last frame byte. On accept:
    - write: queue response 0x4B 'K', go to TX_RESP;
    - read: go to BUS_RSP.
  - BUS_RSP: on dbus_rsp_ready:
    - dbus_rsp_error=1: queue 0x45 'E';
    - else: queue 0x4B followed by the 4 data bytes, MSB first (5 bytes).
    - If RSP_TIMEOUT_CYCLES elapse first, queue 0x54 'T'.
    - Go to TX_RESP.
  - TX_RESP: present bytes in order with standard valid/ready. tx_vld stays asserted and tx_data stays stable until the cycle where tx_vld && tx_rdy. After the last byte is consumed, tx_vld=0 and state=IDLE the next cycle.
- Inter-byte timeout: in ADDR/DATA, a counter resets on each rx_valid. When it reaches BYTE_TIMEOUT_CYCLES, discard the partial frame, return to IDLE and emit no response.
- Byte drop: rx_valid in BUS_CMD, BUS_RSP or TX_RESP drops the byte and pulses rx_overrun for 1 cycle (the cycle after rx_valid). Parser state is unaffected.
- Write payload: a write cmd is never issued with a partial address or data word.
- dbus_cmd_ready behaviour: if dbus_cmd_ready is already high when valid rises, accept takes 1 cycle. There is no BUS_CMD timeout; the block waits indefinitely.
- Stray responses: dbus_rsp_ready outside BUS_RSP is ignored.
- Simultaneous events: timeout terminal count and rx_valid in the same cycle → the byte wins and the counter restarts. Response timeout and dbus_rsp_ready in the same cycle → the response wins.

Test Plan:
- Write frame 57 80 00 00 0C 00 00 00 05, cmd_ready tied 1 → one cmd: wr=1, addr=0x8000000C, data=0x00000005, size=2'b10; then TX byte 0x4B; busy back to 0.
- Read frame 52 00 00 01 00; rsp_ready 3 cycles after accept with data 0xDEADBEEF → TX bytes 4B DE AD BE EF, in order.
- Read with dbus_rsp_error=1 → single TX 0x45. Read with no response (RSP_TIMEOUT_CYCLES=16) → TX 0x54 after 16 cycles, then IDLE.
- Send 57 12 34, then silence beyond BYTE_TIMEOUT_CYCLES=100 → no cmd, no TX. A following full read frame works normally.
- During TX_RESP with tx_rdy held low 50 cycles, inject rx bytes → tx_vld/tx_data stable throughout, one rx_overrun pulse per dropped byte, response completes intact.
- Assert reset during BUS_CMD (cmd_ready=0) → next cycle dbus_cmd_valid=0, tx_vld=0, busy=0. Junk byte 0x00 in IDLE → ignored, no overrun.
